// File: rtl/maq_bcd_mod.sv
// Two-digit BCD modulo-MOD up/down counter with validated load and wrap pulses; MAQC_SATURATE_EN clamps at the ends.
// Latency: one cycle from inc/dec/load to updated digits and carry/borrow/load_err pulse; tc/zero are combinational.
// Backpressure: none; every request is acted on at the next edge (reset > load > count).
module maq_bcd_mod #(
    parameter int MOD     = 60,
    parameter int MSD_W   = 3,
    parameter int RST_VAL = 0
) (
    input  logic             maqc_clock,
    input  logic             maqc_reset,
    input  logic             maqc_inc,
    input  logic             maqc_dec,
    input  logic             maqc_load,
    input  logic [3:0]       maqc_load_lsd,
    input  logic [MSD_W-1:0] maqc_load_msd,
    output logic [3:0]       maqc_lsd,
    output logic [MSD_W-1:0] maqc_msd,
    output logic             maqc_tc,
    output logic             maqc_zero,
    output logic             maqc_carry,
    output logic             maqc_borrow,
    output logic             maqc_load_err
);

    localparam logic [3:0]       RST_LSD = 4'(RST_VAL % 10);
    localparam logic [MSD_W-1:0] RST_MSD = MSD_W'(RST_VAL / 10);
    localparam logic [3:0]       MAX_LSD = 4'((MOD - 1) % 10);
    localparam logic [MSD_W-1:0] MAX_MSD = MSD_W'((MOD - 1) / 10);

    logic [3:0]       lsd_q, lsd_d;
    logic [MSD_W-1:0] msd_q, msd_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             err_q, err_d;
    logic [31:0]      load_val;
    logic             load_ok;
    logic             count_up;
    logic             count_dn;

    // Full-width load value so any tens code, even an out-of-range one, compares correctly.
    assign load_val = 32'(maqc_load_msd) * 32'd10 + 32'(maqc_load_lsd);
    assign load_ok  = (maqc_load_lsd <= 4'd9) && (load_val < 32'(MOD));
    assign count_up = maqc_inc & ~maqc_dec;
    assign count_dn = maqc_dec & ~maqc_inc;

    assign maqc_tc   = (lsd_q == MAX_LSD) && (msd_q == MAX_MSD);
    assign maqc_zero = (lsd_q == 4'd0) && (msd_q == '0);

    always_comb begin
        lsd_d    = lsd_q;
        msd_d    = msd_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        err_d    = 1'b0;
        if (maqc_load) begin
            if (load_ok) begin
                lsd_d = maqc_load_lsd;
                msd_d = maqc_load_msd;
            end else begin
                err_d = 1'b1;
            end
        end else if (count_up) begin
            if (maqc_tc) begin
`ifdef MAQC_SATURATE_EN
                lsd_d = lsd_q;
`else
                lsd_d   = 4'd0;
                msd_d   = '0;
                carry_d = 1'b1;
`endif
            end else if (lsd_q == 4'd9) begin
                lsd_d = 4'd0;
                msd_d = msd_q + MSD_W'(1);
            end else begin
                lsd_d = lsd_q + 4'd1;
            end
        end else if (count_dn) begin
            if (maqc_zero) begin
`ifdef MAQC_SATURATE_EN
                lsd_d = lsd_q;
`else
                lsd_d    = MAX_LSD;
                msd_d    = MAX_MSD;
                borrow_d = 1'b1;
`endif
            end else if (lsd_q == 4'd0) begin
                lsd_d = 4'd9;
                msd_d = msd_q - MSD_W'(1);
            end else begin
                lsd_d = lsd_q - 4'd1;
            end
        end
    end

    always_ff @(posedge maqc_clock) begin
        if (maqc_reset) begin
            lsd_q    <= RST_LSD;
            msd_q    <= RST_MSD;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            lsd_q    <= lsd_d;
            msd_q    <= msd_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            err_q    <= err_d;
        end
    end

    assign maqc_lsd      = lsd_q;
    assign maqc_msd      = msd_q;
    assign maqc_carry    = carry_q;
    assign maqc_borrow   = borrow_q;
    assign maqc_load_err = err_q;

endmodule
